// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID skid stage.
//   fetch_pkt_t  : {pc, instr} packet moved from fetch to decode
//   skid_state_t : occupancy of the two-entry buffer (EMPTY/ONE/FULL)
//   RESET_PC / NOP_INSTR : values presented after reset or flush
package ifid_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h8000_0000;
  // addi x0, x0, 0
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/ifid_perf_ctr.sv
// Performance counters for the IF/ID stage (only built with IFID_PERF_CNT_EN).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   stall         : presented packet not accepted this cycle
//   flush         : flush asserted this cycle
//   stall_cycles  : count of stall cycles, wraps at 2^32
//   flush_count   : count of flush cycles, wraps at 2^32
// Counters clear on reset only; flush does not clear them.
module ifid_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall ? stall_q + 32'd1 : stall_q;
    flush_d = flush ? flush_q + 32'd1 : flush_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline boundary: valid/ready handshake with a two-entry skid buffer.
// The main entry drives out_*; the skid entry absorbs one packet when decode
// stalls. in_ready is decoded purely from the state register, so there is no
// combinational path from out_ready back to fetch. Sustains one packet/cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous discard of held packets, presents a NOP
//   in_valid/in_ready   : fetch handshake (in_ready registered)
//   in_pc/in_instr      : fetch packet
//   out_valid/out_ready : decode handshake
//   out_pc/out_instr    : presented packet (holds last value while empty)
// Optional (macro IFID_PERF_CNT_EN): stall_cycles, flush_count outputs.
module ifid_skid_stage #(
  parameter int unsigned          ADDR_WIDTH = ifid_pkg::ADDR_WIDTH,
  parameter int unsigned          DATA_WIDTH = ifid_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = ifid_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = ifid_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  import ifid_pkg::*;

  skid_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] main_pc_q, main_pc_d;
  logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;

  logic in_fire, out_fire;

  // Both handshakes come straight from the state register.
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign in_ready  = (state_q != FULL);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      // Any same-cycle incoming packet is dropped; a same-cycle out_fire is
      // left for decode to squash.
      state_d      = EMPTY;
      main_pc_d    = RESET_PC;
      main_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (in_fire) begin
            state_d      = FULL;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
          end else if (out_fire) begin
            // Main entry keeps the last presented packet while empty.
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d      = ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

`ifdef IFID_PERF_CNT_EN
  ifid_perf_ctr u_perf_ctr (
    .clk          (clk),
    .reset        (reset),
    .stall        (out_valid & ~out_ready),
    .flush        (flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_ifid_skid_stage;
  import ifid_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  ifid_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packets held, in presentation order (at most two).
  fetch_pkt_t  held[$];
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    held.delete();
    last_pc    = RESET_PC;
    last_instr = NOP_INSTR;
    m_stall    = '0;
    m_flush    = '0;
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] epc, ein;
    ev  = (held.size() > 0);
    epc = ev ? held[0].pc : last_pc;
    ein = ev ? held[0].instr : last_instr;
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("in_ready", {31'b0, in_ready}, {31'b0, held.size() < 2});
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, ein);
`ifdef IFID_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                            input logic ordy, input logic fl);
    fetch_pkt_t p;
    logic       acc_in, acc_out;
    acc_in  = iv && (held.size() < 2);
    acc_out = (held.size() > 0) && ordy;
    if (held.size() > 0 && !ordy) m_stall++;
    if (fl) m_flush++;
    if (fl) begin
      held.delete();
      last_pc    = RESET_PC;
      last_instr = NOP_INSTR;
    end else begin
      if (acc_out) begin
        p          = held.pop_front();
        last_pc    = p.pc;
        last_instr = p.instr;
      end
      if (acc_in) begin
        p.pc    = pc;
        p.instr = ins;
        held.push_back(p);
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    model_step(iv, pc, ins, ordy, fl);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back streaming with decode always ready.
    cycle(1'b1, 32'h8000_0000, 32'h0010_0093, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0004, 32'h0020_0113, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0008, 32'h0030_0193, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure for three cycles mid-stream, then drain.
    cycle(1'b1, 32'h8000_0100, 32'h1111_1111, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0104, 32'h2222_2222, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0108, 32'h3333_3333, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0108, 32'h3333_3333, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0108, 32'h3333_3333, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0108, 32'h3333_3333, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, then flush while FULL with a packet offered.
    cycle(1'b1, 32'h8000_0200, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0204, 32'hAAAA_0002, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0208, 32'hAAAA_0003, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("post_flush_pc", out_pc, 32'h8000_0000);
    chk("post_flush_instr", out_instr, 32'h0000_0013);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Second flush while idle; counters must hold apart from flush_count.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to FULL, then assert reset between clock edges.
    cycle(1'b1, 32'h8000_0300, 32'hBBBB_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0304, 32'hBBBB_0002, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_pc", out_pc, RESET_PC);
    chk("async_rst_instr", out_instr, NOP_INSTR);
`ifdef IFID_PERF_CNT_EN
    chk("async_rst_stall", stall_cycles, 32'd0);
    chk("async_rst_flush", flush_count, 32'd0);
`endif
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
Parametrised IF/ID pipeline boundary with a valid/ready handshake and a 2-entry skid buffer. Replaces the stall/flush-vector register.
- Upstream side: fetch unit.
- Downstream side: decode.
- Sustains 1 packet/cycle.
- in_ready is fully registered, which breaks the combinational ready path from decode back to fetch.
- flush discards all held packets and presents a NOP.

Parameters:
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h8000_0000, out_pc value after reset/flush
NOP_INSTR, 32'h0000_0013, out_instr value after reset/flush (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all held packets
in_valid  in  1  fetch packet valid
in_ready  out  1  stage can accept; registered
in_pc  in  ADDR_WIDTH  fetch PC
in_instr  in  DATA_WIDTH  fetched instruction
out_valid  out  1  packet to decode valid
out_ready  in  1  decode accepts
out_pc  out  ADDR_WIDTH  PC of presented packet
out_instr  out  DATA_WIDTH  presented instruction

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry drives out_*; skid entry holds the overflow packet.
- Valid/ready derivation: out_valid = main valid; in_ready = !skid valid, derived from state only and never from out_ready.
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_pc RESET_PC, out_instr NOP_INSTR, skid contents 0.
- States and transitions:
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire only -> FULL, skid<=in. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY.
- Ordering: packets are never reordered, duplicated or dropped, except on flush.
- Stability: while out_valid & !out_ready, out_pc/out_instr are stable.
- EMPTY outputs: out_pc/out_instr retain the last presented value, or RESET_PC/NOP_INSTR after reset/flush.
- Flush: priority below reset, above all else. Next state EMPTY, out_pc<=RESET_PC, out_instr<=NOP_INSTR. A same-cycle in_fire packet is discarded. in_ready=1 the following cycle.
- Flush does not suppress a same-cycle out_fire; decode owns squash of that packet.
- Reset mid-transfer: immediate return to reset values; no partial state survives.
- Illegal state encoding: recover to EMPTY.

Optional Feature:
IFID_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle out_valid & !out_ready.
  - flush_count increments each cycle flush=1.
  - Both reset to 0 on reset only, never on flush, and wrap modulo 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ifid_pkg:
  - typedef fetch_pkt_t {pc, instr}, sized from package-level ADDR_WIDTH/DATA_WIDTH constants.
  - enum skid_state_t {EMPTY, ONE, FULL}.
  - NOP_INSTR constant.
- Sub-module ifid_perf_ctr holds both counters; it is instantiated only under IFID_PERF_CNT_EN. The core needs no further split.

Test Plan:
- Reset released, out_ready=1, in_valid=1 with pc 0x8000_0000,+4,+8 on consecutive cycles -> out_valid from the next cycle, same order, 1/cycle, in_ready constantly 1.
- out_ready=0 for 3 cycles during streaming -> one packet absorbed into skid. in_ready falls the cycle after FULL. No loss. On out_ready=1, skid packet presented after main.
- FULL and out_ready=1 for one cycle -> state ONE, out_pc=skid PC, in_ready=1 next cycle.
- flush=1 while FULL with in_valid=1 -> next cycle out_valid=0, out_pc=0x8000_0000, out_instr=0x0000_0013, in_ready=1. Incoming packet absent from output.
- reset asserted asynchronously mid-stream while FULL -> outputs reach reset values without a clock edge.
- With IFID_PERF_CNT_EN: 5 backpressured cycles and 2 flushes -> stall_cycles=5, flush_count=2. A third flush leaves stall_cycles unchanged.
